// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin share of the register-file write port among NUM_REQ writeback sources (optional RF_WB_BYPASS_EN adds read-port forwarding)
module regfile_wb_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5
) (
    input  logic                        Clk,
    input  logic                        Rst_n,
    input  logic                        Flush,
    input  logic [NUM_REQ-1:0]          Req,
    input  logic [NUM_REQ*ADDR_W-1:0]   ReqReg,
    input  logic [NUM_REQ*DATA_W-1:0]   ReqData,
`ifdef RF_WB_BYPASS_EN
    input  logic [ADDR_W-1:0]           ReadRegister1,
    input  logic [ADDR_W-1:0]           ReadRegister2,
    input  logic [DATA_W-1:0]           DataRead1,
    input  logic [DATA_W-1:0]           DataRead2,
    output logic [DATA_W-1:0]           BypData1,
    output logic [DATA_W-1:0]           BypData2,
`endif
    output logic [NUM_REQ-1:0]          Gnt,
    output logic                        RegWrite,
    output logic [ADDR_W-1:0]           WriteRegister,
    output logic [DATA_W-1:0]           WriteData,
    output logic                        Busy
);
    localparam int PW = $clog2(NUM_REQ);

    logic [PW-1:0]       ptr, sel, nxt_ptr, idx;
    logic [PW:0]         sum;
    logic [NUM_REQ-1:0]  gnt_rr;
    logic                found, accept;
    logic [ADDR_W-1:0]   sel_reg;
    logic [DATA_W-1:0]   sel_data;

    // Round-robin scan starting at ptr; the first requester found wins
    always_comb begin
        gnt_rr = '0;
        found  = 1'b0;
        sum    = '0;
        idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, ptr} + (PW+1)'(k);
            idx = (sum >= (PW+1)'(NUM_REQ)) ? PW'(sum - (PW+1)'(NUM_REQ)) : sum[PW-1:0];
            if (!found && Req[idx]) begin
                gnt_rr[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

    // Encode the granted source and compute the wrapped next pointer
    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (gnt_rr[i]) sel = PW'(i);
        nxt_ptr = (sel == PW'(NUM_REQ-1)) ? '0 : sel + PW'(1);
    end

    assign Gnt      = (Flush || !Rst_n) ? '0 : gnt_rr;
    assign accept   = |Gnt;
    assign sel_reg  = ReqReg[int'(sel)*ADDR_W +: ADDR_W];
    assign sel_data = ReqData[int'(sel)*DATA_W +: DATA_W];
    assign Busy     = RegWrite;

    // Stage the accepted write; writes to x0 retire the source but never enable the port
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            RegWrite      <= 1'b0;
            WriteRegister <= '0;
            WriteData     <= '0;
            ptr           <= '0;
        end else if (Flush) begin
            RegWrite <= 1'b0;
            ptr      <= '0;
        end else if (accept) begin
            RegWrite      <= |sel_reg;
            WriteRegister <= sel_reg;
            WriteData     <= sel_data;
            ptr           <= nxt_ptr;
        end else begin
            RegWrite <= 1'b0;
        end
    end

`ifdef RF_WB_BYPASS_EN
    assign BypData1 = (RegWrite && WriteRegister == ReadRegister1 && |ReadRegister1) ? WriteData : DataRead1;
    assign BypData2 = (RegWrite && WriteRegister == ReadRegister2 && |ReadRegister2) ? WriteData : DataRead2;
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: randomized scoreboard bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
    localparam int N = 3;

    logic            Clk = 1'b0;
    logic            Rst_n = 1'b0;
    logic            Flush = 1'b0;
    logic [N-1:0]    Req = '1;
    logic [N*5-1:0]  ReqReg = '0;
    logic [N*32-1:0] ReqData = '0;
    logic [N-1:0]    Gnt;
    logic            RegWrite, Busy;
    logic [4:0]      WriteRegister;
    logic [31:0]     WriteData;
`ifdef RF_WB_BYPASS_EN
    logic [4:0]      ReadRegister1 = '0, ReadRegister2 = '0;
    logic [31:0]     DataRead1 = '0, DataRead2 = '0;
    logic [31:0]     BypData1, BypData2;
`endif

    regfile_wb_arbiter #(.NUM_REQ(N), .DATA_W(32), .ADDR_W(5)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Flush(Flush), .Req(Req), .ReqReg(ReqReg), .ReqData(ReqData),
`ifdef RF_WB_BYPASS_EN
        .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
        .DataRead1(DataRead1), .DataRead2(DataRead2), .BypData1(BypData1), .BypData2(BypData2),
`endif
        .Gnt(Gnt), .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData), .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    int checks = 0, errors = 0;
    bit mon_en = 1'b0;
    logic [N-1:0] exp_gnt = '0;
    logic [36:0] wq[$];
    logic [36:0] e;
    logic        exp_rw;

    bit          pend [N];
    logic [4:0]  preg [N];
    logic [31:0] pdata[N];
    int          mptr = 0;
    logic [31:0] rf[32];
    logic [31:0] ref_rf[32];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // Register file the write port feeds; commits whatever the DUT presents at each edge
    always @(posedge Clk)
        if (Rst_n && RegWrite) rf[WriteRegister] <= WriteData;

    // Monitor: compares grant, write port and (optionally) forwarded read data at each negedge
    always @(negedge Clk) begin
        if (mon_en) begin
            check("gnt", 64'(Gnt), 64'(exp_gnt));
            exp_rw = wq.size() > 0;
            check("regwrite", 64'(RegWrite), 64'(exp_rw));
            check("busy", 64'(Busy), 64'(exp_rw));
            e = exp_rw ? wq.pop_front() : '0;
            if (exp_rw && RegWrite) check("wb", {27'd0, WriteRegister, WriteData}, 64'(e));
`ifdef RF_WB_BYPASS_EN
            check("byp1", 64'(BypData1),
                  64'((exp_rw && e[36:32] == ReadRegister1 && ReadRegister1 != 0) ? e[31:0] : DataRead1));
            check("byp2", 64'(BypData2),
                  64'((exp_rw && e[36:32] == ReadRegister2 && ReadRegister2 != 0) ? e[31:0] : DataRead2));
`endif
        end
    end

    task automatic load(input int i, input logic [4:0] r, input logic [31:0] d);
        pend[i] = 1'b1;
        preg[i] = r;
        pdata[i] = d;
    endtask

    // One cycle: drive pending requests, predict the grant, then retire it in the model after the edge
    task automatic step(input bit fl);
        int g;
        g = -1;
        for (int i = 0; i < N; i++) begin
            Req[i] = pend[i];
            ReqReg[i*5 +: 5] = preg[i];
            ReqData[i*32 +: 32] = pdata[i];
        end
        Flush = fl;
`ifdef RF_WB_BYPASS_EN
        ReadRegister1 = 5'($urandom_range(0, 7));
        ReadRegister2 = 5'($urandom_range(0, 7));
        DataRead1 = $urandom;
        DataRead2 = $urandom;
`endif
        if (!fl)
            for (int k = 0; k < N; k++)
                if (g < 0 && pend[(mptr + k) % N]) g = (mptr + k) % N;
        exp_gnt = (g >= 0) ? N'(1 << g) : '0;
        @(posedge Clk);
        if (g >= 0) begin
            if (preg[g] != 0) begin
                wq.push_back({preg[g], pdata[g]});
                ref_rf[preg[g]] = pdata[g];
            end
            pend[g] = 1'b0;
            mptr = (g + 1) % N;
        end
        if (fl) mptr = 0;
        #1;
    endtask

    initial begin
        logic [31:0] saved;
        for (int i = 0; i < 32; i++) begin
            rf[i] = '0;
            ref_rf[i] = '0;
        end
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0;
            preg[i] = '0;
            pdata[i] = '0;
        end
        #12;
        check("rst_gnt", 64'(Gnt), 64'(0));
        check("rst_regwrite", 64'(RegWrite), 64'(0));
        check("rst_wreg", 64'(WriteRegister), 64'(0));
        check("rst_wdata", 64'(WriteData), 64'(0));
        check("rst_busy", 64'(Busy), 64'(0));
        @(posedge Clk);
        #1;
        Rst_n = 1'b1;
        mon_en = 1'b1;
        for (int i = 0; i < N; i++) load(i, 5'(i + 1), 32'h100 + i);
        step(0);
        step(0);
        step(0);
        load(1, 5'd7, 32'hDEADBEEF);
        step(0);
        step(0);
        for (int c = 0; c < 6; c++) begin
            for (int i = 0; i < N; i++) if (!pend[i]) load(i, 5'(10 + i), $urandom);
            step(0);
        end
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        load(2, 5'd0, 32'h5);
        step(0);
        step(0);
        load(0, 5'd3, 32'hCAFE0003);
        step(1);
        step(0);
        step(0);
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++)
                if (!pend[i] && $urandom_range(0, 99) < 50) load(i, 5'($urandom_range(0, 31)), $urandom);
            step($urandom_range(0, 9) == 0);
        end
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        step(0);
        saved = ref_rf[9];
        load(0, 5'd9, 32'hBAD00009);
        step(0);
        mon_en = 1'b0;
        Rst_n = 1'b0;
        #1;
        check("midrst_regwrite", 64'(RegWrite), 64'(0));
        check("midrst_wdata", 64'(WriteData), 64'(0));
        check("midrst_gnt", 64'(Gnt), 64'(0));
        wq.delete();
        ref_rf[9] = saved;
        mptr = 0;
        @(posedge Clk);
        #1;
        Rst_n = 1'b1;
        mon_en = 1'b1;
        load(1, 5'd12, 32'h0000ABCD);
        load(2, 5'd13, 32'h0000DCBA);
        step(0);
        step(0);
        step(0);
        step(0);
        mon_en = 1'b0;
        for (int i = 0; i < 32; i++) check($sformatf("rf[%0d]", i), 64'(rf[i]), 64'(ref_rf[i]));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
